pwm_3ph_deadtime: RTL

- Downstream consumer of the three-phase sine/triangle lookup ROM.
- Compares the three 16-bit reference levels (out1/out2/out3 of the ROM) against an internal symmetric triangular carrier.
- Produces six complementary gate signals (high/low side per phase) with programmable dead time.
- Emits a once-per-carrier-period sync pulse so the upstream phase accumulator advances the ROM address once per PWM period.

---
 rtl/pwm_3ph_deadtime_if.sv | 27 ++
 rtl/pwm_3ph_deadtime.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_3ph_deadtime_if.sv
// Control and gate-drive bundle for the three-phase dead-time PWM.
// The master side supplies enable and reference levels. The slave side returns
// the six gate drives, the period sync pulse and the carrier value.
interface pwm_3ph_deadtime_if;
  logic        en;
  logic [15:0] ref1;
  logic [15:0] ref2;
  logic [15:0] ref3;
  logic        hi1;
  logic        lo1;
  logic        hi2;
  logic        lo2;
  logic        hi3;
  logic        lo3;
  logic        sync;
  logic [15:0] carrier;

  modport master (
    output en, ref1, ref2, ref3,
    input  hi1, lo1, hi2, lo2, hi3, lo3, sync, carrier
  );

  modport slave (
    input  en, ref1, ref2, ref3,
    output hi1, lo1, hi2, lo2, hi3, lo3, sync, carrier
  );
endinterface

// File: rtl/pwm_3ph_deadtime.sv
// Three-phase PWM generator with a symmetric triangular carrier.
// Each phase compares its period-latched reference against the carrier.
// Each phase drives a complementary high/low gate pair.
// A per-phase dead-time FSM keeps both gates of a pair low around every switch.
module pwm_3ph_deadtime #(
  parameter int unsigned STEP      = 64,
  parameter int unsigned DEAD_TIME = 8,
  parameter int unsigned DT_WIDTH  = 8
) (
  input logic                clk,
  input logic                rst,
  pwm_3ph_deadtime_if.slave  bus
);

  localparam logic [16:0]         StepW      = 17'(STEP);
  localparam logic [16:0]         CarrierTop = 17'h0_ffff;
  localparam logic [DT_WIDTH-1:0] DeadLoad   = DT_WIDTH'(DEAD_TIME);
  localparam logic [DT_WIDTH-1:0] CntOne     = DT_WIDTH'(1);

  typedef enum logic [1:0] {
    StDead = 2'd0,
    StOnHi = 2'd1,
    StOnLo = 2'd2
  } phase_st_e;

  // Carrier and period bookkeeping.
  logic [15:0]       carrier_q, carrier_d;
  logic              dir_down_q, dir_down_d;
  logic              sync_q, sync_d;
  logic [2:0][15:0]  shadow_q, shadow_d;
  logic [16:0]       up_sum;
  logic              at_valley;

  // Compare results and per-phase dead-time FSMs.
  logic [2:0]                raw_q, raw_d;
  phase_st_e                 state_q [3];
  phase_st_e                 state_d [3];
  logic [2:0]                tgt_q, tgt_d;
  logic [2:0][DT_WIDTH-1:0]  cnt_q, cnt_d;

  // The carrier arithmetic is 17 bits wide so that the peak test cannot wrap.
  assign up_sum    = {1'b0, carrier_q} + StepW;
  assign at_valley = dir_down_q && ({1'b0, carrier_q} < StepW);

  // Carrier next state. The valley edge also restarts the period and latches the refs.
  always_comb begin
    carrier_d  = carrier_q;
    dir_down_d = dir_down_q;
    sync_d     = 1'b0;
    shadow_d   = shadow_q;
    if (bus.en) begin
      if (!dir_down_q) begin
        if (up_sum >= CarrierTop) begin
          carrier_d  = 16'hffff;
          dir_down_d = 1'b1;
        end else begin
          carrier_d  = up_sum[15:0];
        end
      end else if (at_valley) begin
        carrier_d  = 16'h0000;
        dir_down_d = 1'b0;
        sync_d     = 1'b1;
        shadow_d   = {bus.ref3, bus.ref2, bus.ref1};
      end else begin
        carrier_d  = carrier_q - StepW[15:0];
      end
    end
  end

  // Carrier, direction, sync and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q  <= 16'h0000;
      dir_down_q <= 1'b0;
      sync_q     <= 1'b0;
      shadow_q   <= '0;
    end else begin
      carrier_q  <= carrier_d;
      dir_down_q <= dir_down_d;
      sync_q     <= sync_d;
      shadow_q   <= shadow_d;
    end
  end

  // Strictly-greater compare, so ref=0 never drives the high side.
  always_comb begin
    raw_d = '0;
    for (int i = 0; i < 3; i++) begin
      raw_d[i] = (shadow_q[i] > carrier_q);
    end
  end

  // Registered compare outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= '0;
    end else begin
      raw_q <= raw_d;
    end
  end

  // Dead-time FSM next state. A gate turns on only after DEAD_TIME cycles of stable raw.
  always_comb begin
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      if (!bus.en) begin
        // A disabled phase parks in dead time and tracks raw, ready to re-arm.
        state_d[i] = StDead;
        tgt_d[i]   = raw_q[i];
        cnt_d[i]   = DeadLoad;
      end else begin
        unique case (state_q[i])
          StOnHi: begin
            if (!raw_q[i]) begin
              state_d[i] = StDead;
              tgt_d[i]   = 1'b0;
              cnt_d[i]   = DeadLoad;
            end
          end
          StOnLo: begin
            if (raw_q[i]) begin
              state_d[i] = StDead;
              tgt_d[i]   = 1'b1;
              cnt_d[i]   = DeadLoad;
            end
          end
          StDead: begin
            if (raw_q[i] != tgt_q[i]) begin
              // A raw glitch inside the dead band restarts the full wait.
              tgt_d[i] = raw_q[i];
              cnt_d[i] = DeadLoad;
            end else if (cnt_q[i] == CntOne) begin
              state_d[i] = tgt_q[i] ? StOnHi : StOnLo;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          default: begin
            state_d[i] = StDead;
            tgt_d[i]   = raw_q[i];
            cnt_d[i]   = DeadLoad;
          end
        endcase
      end
    end
  end

  // Dead-time FSM state registers. Reset parks every phase in dead time aimed at the low side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StDead;
      end
      tgt_q <= '0;
      cnt_q <= {3{DeadLoad}};
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
      end
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end

  // Gates decode straight from the registered state, so a pair can never overlap.
  assign bus.hi1     = (state_q[0] == StOnHi);
  assign bus.lo1     = (state_q[0] == StOnLo);
  assign bus.hi2     = (state_q[1] == StOnHi);
  assign bus.lo2     = (state_q[1] == StOnLo);
  assign bus.hi3     = (state_q[2] == StOnHi);
  assign bus.lo3     = (state_q[2] == StOnLo);
  assign bus.sync    = sync_q;
  assign bus.carrier = carrier_q;

  // Invariants: sync marks the valley, and no pair ever shoots through.
  a_sync_valley: assert property (@(posedge clk) disable iff (rst)
    sync_q |-> (carrier_q == 16'h0000));
  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !((bus.hi1 && bus.lo1) || (bus.hi2 && bus.lo2) || (bus.hi3 && bus.lo3)));

endmodule
